axilite_noc_width_downsizer: RTL and testbench



---
 rtl/axilite_noc_width_downsizer_if.sv | 28 ++
 rtl/axilite_noc_width_downsizer.sv | 96 +++++++++
 tb/tb_axilite_noc_width_downsizer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axilite_noc_width_downsizer_if.sv
// Wide-word-in / narrow-beat-out handshake bundle for the NoC width downsizer.
// The slave modport is the downsizer's view, the master modport the environment's view.
interface axilite_noc_width_downsizer_if #(
  parameter int DATA_INPUT_WIDTH  = 512,
  parameter int DATA_OUTPUT_WIDTH = 64
);
  localparam int RATIO = DATA_INPUT_WIDTH / DATA_OUTPUT_WIDTH;
  localparam int CNT_W = $clog2(RATIO) + 1;

  logic                         inp_valid;
  logic                         inp_ready;
  logic [DATA_INPUT_WIDTH-1:0]  inp_data;
  logic [CNT_W-1:0]             inp_beats;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_OUTPUT_WIDTH-1:0] out_data;
  logic                         out_last;

  modport slave (
    input  inp_valid, inp_data, inp_beats, out_ready,
    output inp_ready, out_valid, out_data, out_last
  );

  modport master (
    output inp_valid, inp_data, inp_beats, out_ready,
    input  inp_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/axilite_noc_width_downsizer.sv
// Wide-to-narrow serializer: one DATA_INPUT_WIDTH word in, 1..RATIO DATA_OUTPUT_WIDTH
// beats out, lowest slice first, valid/ready on both sides, no bubble between words.
module axilite_noc_width_downsizer #(
  parameter int DATA_INPUT_WIDTH  = 512,
  parameter int DATA_OUTPUT_WIDTH = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  axilite_noc_width_downsizer_if.slave        bus
);
  localparam int RATIO = DATA_INPUT_WIDTH / DATA_OUTPUT_WIDTH;
  localparam int CNT_W = $clog2(RATIO) + 1;
  localparam logic [CNT_W-1:0] RATIO_CNT = CNT_W'(RATIO);
  localparam logic [CNT_W-1:0] ZERO_CNT  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_CNT   = CNT_W'(2);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                      state_r;
  logic [DATA_INPUT_WIDTH-1:0] hold_r;
  logic [CNT_W-1:0]            remaining_r;
  logic                        out_valid_r;
  logic                        out_last_r;

  logic [CNT_W-1:0]            eff_beats_s;
  logic                        done_s;
  logic                        advance_s;
  logic                        inp_ready_s;
  logic                        accept_s;

  // A zero or oversized beat request means the whole word.
  assign eff_beats_s = ((bus.inp_beats == ZERO_CNT) || (bus.inp_beats > RATIO_CNT)) ?
                       RATIO_CNT : bus.inp_beats;

  assign done_s      = out_valid_r && bus.out_ready && out_last_r;
  assign advance_s   = out_valid_r && bus.out_ready && !out_last_r;
  // Ready during the final beat's handshake lets the next word follow with no bubble.
  assign inp_ready_s = rst_n && ((state_r == IDLE) || done_s);
  assign accept_s    = bus.inp_valid && inp_ready_s;

  assign bus.inp_ready = inp_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = hold_r[DATA_OUTPUT_WIDTH-1:0];
  assign bus.out_last  = out_last_r;

  // Word capture, beat advance and return to idle; out_last is precomputed for the next beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      hold_r      <= {DATA_INPUT_WIDTH{1'b0}};
      remaining_r <= ZERO_CNT;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            hold_r      <= bus.inp_data;
            remaining_r <= eff_beats_s;
            out_last_r  <= (eff_beats_s == ONE_CNT);
            out_valid_r <= 1'b1;
            state_r     <= SEND;
          end
        end
        SEND: begin
          if (accept_s) begin
            hold_r      <= bus.inp_data;
            remaining_r <= eff_beats_s;
            out_last_r  <= (eff_beats_s == ONE_CNT);
            out_valid_r <= 1'b1;
            state_r     <= SEND;
          end else if (done_s) begin
            remaining_r <= ZERO_CNT;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else if (advance_s) begin
            hold_r      <= hold_r >> DATA_OUTPUT_WIDTH;
            remaining_r <= remaining_r - ONE_CNT;
            out_last_r  <= (remaining_r == TWO_CNT);
          end
        end
        default: begin
          remaining_r <= ZERO_CNT;
          out_last_r  <= 1'b0;
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axilite_noc_width_downsizer.sv
// Bench for the width downsizer: a beat-queue model checked every cycle, directed words,
// and a RATIO=1 instance with hand-computed expectations.
module tb_axilite_noc_width_downsizer;
  localparam int IW = 512;
  localparam int OW = 64;
  localparam int R  = IW / OW;
  localparam int CW = $clog2(R) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axilite_noc_width_downsizer_if #(.DATA_INPUT_WIDTH(IW), .DATA_OUTPUT_WIDTH(OW)) bus ();
  axilite_noc_width_downsizer_if #(.DATA_INPUT_WIDTH(OW), .DATA_OUTPUT_WIDTH(OW)) bus1 ();

  axilite_noc_width_downsizer #(.DATA_INPUT_WIDTH(IW), .DATA_OUTPUT_WIDTH(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  axilite_noc_width_downsizer #(.DATA_INPUT_WIDTH(OW), .DATA_OUTPUT_WIDTH(OW)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  typedef struct packed {
    logic [OW-1:0] d;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int    acc_cnt = 0;
  int    beat_cnt = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int eff_beats(input logic [CW-1:0] b);
    return ((b == '0) || (int'(b) > R)) ? R : int'(b);
  endfunction

  function automatic beat_t mk_beat(input logic [OW-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    return b;
  endfunction

  function automatic logic [IW-1:0] mk_word(input logic [63:0] base, input logic [63:0] step);
    logic [IW-1:0] w;
    for (int k = 0; k < R; k++) w[k*OW +: OW] = base + step * 64'(k);
    return w;
  endfunction

  // Model: the queue holds every beat still owed downstream; its head is the beat on the wire.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (bus.inp_valid && ((exp_q.size() == 0) || ((exp_q.size() == 1) && bus.out_ready))) begin
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        beat_cnt <= beat_cnt + 1;
      end
      for (int k = 0; k < eff_beats(bus.inp_beats); k++)
        exp_q.push_back(mk_beat(bus.inp_data[k*OW +: OW], k == eff_beats(bus.inp_beats) - 1));
      acc_cnt <= acc_cnt + 1;
    end else if ((exp_q.size() != 0) && bus.out_ready) begin
      void'(exp_q.pop_front());
      beat_cnt <= beat_cnt + 1;
    end
  end

  // Compare every cycle, mid-low-phase, against the model.
  always @(negedge clk) begin
    #1;
    chk("out_valid", bus.out_valid, 64'(exp_q.size() != 0));
    chk("inp_ready", bus.inp_ready,
        64'(rst_n && ((exp_q.size() == 0) || ((exp_q.size() == 1) && bus.out_ready))));
    if (exp_q.size() != 0) begin
      chk("out_data", bus.out_data, exp_q[0].d);
      chk("out_last", bus.out_last, 64'(exp_q[0].l));
    end
  end

  task automatic send_word(input logic [IW-1:0] d, input logic [CW-1:0] b);
    int start = acc_cnt;
    @(negedge clk);
    bus.inp_valid = 1'b1;
    bus.inp_data  = d;
    bus.inp_beats = b;
    for (int i = 0; (i < 50) && (acc_cnt == start); i++) @(negedge clk);
    chk("accept_timeout", 64'(acc_cnt != start), 64'd1);
    bus.inp_valid = 1'b0;
  endtask

  task automatic drain(input int mode);
    int i = 0;
    while ((exp_q.size() != 0) && (i < 200)) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((i % 3) == 0);
      @(negedge clk);
      i++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    int b0;
    int a0;
    logic [IW-1:0] wa;
    logic [IW-1:0] wb;
    rst_n          = 1'b1;
    bus.inp_valid  = 1'b0;
    bus.inp_data   = '0;
    bus.inp_beats  = '0;
    bus.out_ready  = 1'b1;
    bus1.inp_valid = 1'b0;
    bus1.inp_data  = '0;
    bus1.inp_beats = '0;
    bus1.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 64'd0);
    chk("reset_out_last", bus.out_last, 64'd0);
    chk("reset_out_data", bus.out_data, 64'd0);
    chk("reset_inp_ready", bus.inp_ready, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_inp_ready", bus.inp_ready, 64'd1);

    // Full word, inp_beats=0.
    b0 = beat_cnt;
    send_word(mk_word(64'd0, 64'h1111_1111_1111_1111), 4'd0);
    #1 chk("full_beat1_last", bus.out_last, 64'd0);
    @(negedge clk);
    #1 chk("full_beat2_data", bus.out_data, 64'h1111_1111_1111_1111);
    drain(0);
    chk("full_beats", 64'(beat_cnt - b0), 64'd8);

    // Partial word of 3, then oversized request clamped to 8.
    b0 = beat_cnt;
    send_word(mk_word(64'd0, 64'h1111_1111_1111_1111), 4'd3);
    repeat (2) @(negedge clk);
    #1;
    chk("part_beat3_data", bus.out_data, 64'h2222_2222_2222_2222);
    chk("part_beat3_last", bus.out_last, 64'd1);
    drain(0);
    chk("part_beats", 64'(beat_cnt - b0), 64'd3);
    #1 chk("part_idle", bus.out_valid, 64'd0);
    b0 = beat_cnt;
    send_word(mk_word(64'h0100_0000_0000_0000, 64'd1), 4'd9);
    drain(0);
    chk("clamp_beats", 64'(beat_cnt - b0), 64'd8);

    // Backpressure 1,0,0 pattern.
    b0 = beat_cnt;
    send_word(mk_word(64'hBEEF_0000_0000_0000, 64'h10), 4'd0);
    drain(1);
    chk("bp_beats", 64'(beat_cnt - b0), 64'd8);

    // Back-to-back two-beat words with inp_valid held.
    b0 = beat_cnt;
    a0 = acc_cnt;
    wa = mk_word(64'hA000_0000_0000_0000, 64'd1);
    wb = mk_word(64'hB000_0000_0000_0000, 64'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.inp_valid = 1'b1;
    bus.inp_data  = wa;
    bus.inp_beats = 4'd2;
    for (int i = 0; (i < 50) && (acc_cnt == a0); i++) @(negedge clk);
    bus.inp_data = wb;
    @(negedge clk);
    #1;
    chk("b2b_ready_on_last", bus.inp_ready, 64'd1);
    chk("b2b_first_last", bus.out_last, 64'd1);
    for (int i = 0; (i < 50) && (acc_cnt != a0 + 2); i++) @(negedge clk);
    bus.inp_valid = 1'b0;
    #1;
    chk("b2b_no_bubble", bus.out_valid, 64'd1);
    chk("b2b_second_data", bus.out_data, 64'hB000_0000_0000_0000);
    drain(0);
    chk("b2b_beats", 64'(beat_cnt - b0), 64'd4);

    // Reset after beat 2 of 8.
    send_word(mk_word(64'd0, 64'h1111_1111_1111_1111), 4'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", bus.out_valid, 64'd0);
    chk("rst_mid_inp_ready", bus.inp_ready, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_mid_release_ready", bus.inp_ready, 64'd1);
    send_word(mk_word(64'hC0DE_0000_0000_0000, 64'd1), 4'd2);
    #1 chk("rst_mid_new_slice0", bus.out_data, 64'hC0DE_0000_0000_0000);
    drain(0);

    // RATIO=1 instance.
    @(negedge clk);
    bus1.inp_valid = 1'b1;
    bus1.inp_data  = 64'hA5A5_0000_1234_5678;
    bus1.inp_beats = 1'b0;
    #1 chk("r1_latency", bus1.out_valid, 64'd0);
    @(negedge clk);
    #1;
    chk("r1_valid", bus1.out_valid, 64'd1);
    chk("r1_data", bus1.out_data, 64'hA5A5_0000_1234_5678);
    chk("r1_last", bus1.out_last, 64'd1);
    chk("r1_ready", bus1.inp_ready, 64'd1);
    bus1.inp_data  = 64'h0F0F_F0F0_5555_AAAA;
    bus1.inp_beats = 1'b1;
    @(negedge clk);
    #1;
    chk("r1_b2b_valid", bus1.out_valid, 64'd1);
    chk("r1_b2b_data", bus1.out_data, 64'h0F0F_F0F0_5555_AAAA);
    chk("r1_b2b_last", bus1.out_last, 64'd1);
    bus1.inp_valid = 1'b0;
    @(negedge clk);
    #1 chk("r1_idle", bus1.out_valid, 64'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
